// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   // start + 8 data + parity + stop
   localparam int unsigned FRAME_BITS = 11;

   // Watchdog budget: two full frame times expressed in clk cycles.
   function automatic int unsigned calc_timeout_cycles(input int unsigned clk_freq,
                                                       input int unsigned baud_rate);
      longint unsigned num;
      num = 64'(2 * FRAME_BITS) * 64'(clk_freq);
      return 32'(num / 64'(baud_rate));
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer and transmitter handshake bundle around the UART TX arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tx_start;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_done;

   // Producers and the transmitter model drive the bus from the master side.
   modport master (
      output req_valid, req_data, req_last, tx_done,
      input  req_ready, tx_start, tx_data
   );

   // The arbiter sits on the slave side.
   modport slave (
      input  req_valid, req_data, req_last, tx_done,
      output req_ready, tx_start, tx_data
   );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module uart_rr_arbiter import uart_pkg::*; #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         eligible_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         grant_c,
   output logic [$clog2(NUM_REQ)-1:0] idx_c,
   output logic                       any_valid_c
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   int unsigned cand;

   always_comb begin
      grant_c     = '0;
      idx_c       = '0;
      any_valid_c = 1'b0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr_i) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!any_valid_c && eligible_i[cand]) begin
            any_valid_c   = 1'b1;
            idx_c         = IDX_W'(cand);
            grant_c[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with packet locking
// and a watchdog that recovers from a stalled transmitter or abandoned lock.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic                       clk,
   input  logic                       rst_n,
   uart_tx_arbiter_if.slave           bus,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       err_timeout
);

   localparam int unsigned IDX_W          = $clog2(NUM_REQ);
   localparam int unsigned TIMEOUT_CYCLES = calc_timeout_cycles(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      grant_id_q, grant_id_d;
   logic                  lock_q, lock_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  err_q, err_d;

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    grant_oh;
   logic [IDX_W-1:0]      win_idx;
   logic                  any_valid;
   logic [IDX_W-1:0]      next_ptr;
   logic                  wd_run;

   // While locked only the owner of the grant may be served.
   assign eligible = lock_q ? (bus.req_valid & (NUM_REQ'(1) << grant_id_q)) : bus.req_valid;
   assign next_ptr = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .eligible_i  (eligible),
      .ptr_i       (ptr_q),
      .grant_c     (grant_oh),
      .idx_c       (win_idx),
      .any_valid_c (any_valid)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_id_q <= '0;
         lock_q     <= 1'b0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         lock_q     <= lock_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
      end
   end

   // Next-state, byte sequencing and watchdog.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      lock_d     = lock_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      err_d      = 1'b0;
      wd_run     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               tx_data_d  = bus.req_data[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
               grant_id_d = win_idx;
               lock_d     = ~bus.req_last[win_idx];
               cnt_d      = '0;
               state_d    = ISSUE;
            end else if (lock_q && !bus.req_valid[grant_id_q]) begin
               wd_run = 1'b1;
            end
         end
         ISSUE: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A completion on the timeout edge takes priority over the watchdog.
            if (bus.tx_done) begin
               if (!lock_q) begin
                  ptr_d = next_ptr;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               wd_run = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (wd_run) begin
         if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            ptr_d   = next_ptr;
            cnt_d   = '0;
            state_d = IDLE;
         end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE) ? grant_oh : '0;
   assign bus.tx_start  = (state_q == ISSUE);
   assign bus.tx_data   = tx_data_q;
   assign busy          = (state_q != IDLE) | lock_q;
   assign grant_id      = grant_id_q;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned TX_LAT     = 110;

   logic       clk;
   logic       rst_n;
   logic       busy;
   logic [1:0] grant_id;
   logic       err_timeout;
   logic       tx_en;
   int         tx_cnt;
   int         n_assert;
   int         n_fail;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .CLK_FREQ   (1_000_000),
      .BAUD_RATE  (100_000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .busy        (busy),
      .grant_id    (grant_id),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter model: one-cycle tx_done about TX_LAT cycles after tx_start.
   initial begin
      bus.tx_done = 1'b0;
      tx_cnt      = 0;
      forever begin
         @(negedge clk);
         bus.tx_done = 1'b0;
         if (!rst_n) begin
            tx_cnt = 0;
         end else if (bus.tx_start && tx_en) begin
            tx_cnt = TX_LAT;
         end else if (tx_cnt != 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) bus.tx_done = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_byte(input int idx, input logic [7:0] b, input logic last);
      bus.req_data[idx*8 +: 8] = b;
      bus.req_last[idx]        = last;
   endtask

   // Wait (bounded) for a grant, then check which requester is being offered it.
   task automatic wait_ready(input string tag, input int exp_idx);
      int n;
      n = 0;
      #1;
      while (bus.req_ready == '0 && n < 400) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.req_ready), 32'(1) << exp_idx);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (bus.tx_done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.tx_done), 32'd1);
   endtask

   task automatic cycles_to_err(output int n);
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
   endtask

   int n_cyc;
   int order [5];

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      tx_en         = 1'b1;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '1;
      order         = '{0, 1, 2, 3, 0};

      // Reset values
      #1;
      chk("rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst tx_start", 32'(bus.tx_start), 32'd0);
      chk("rst tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst grant_id", 32'(grant_id), 32'd0);
      chk("rst err_timeout", 32'(err_timeout), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single byte from requester 2
      set_byte(2, 8'hA5, 1'b1);
      bus.req_valid = 4'b0100;
      #1;
      chk("single ready same cycle", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = '0;
      chk("single tx_start", 32'(bus.tx_start), 32'd1);
      chk("single tx_data", 32'(bus.tx_data), 32'hA5);
      chk("single busy", 32'(busy), 32'd1);
      tick();
      chk("single start one cycle", 32'(bus.tx_start), 32'd0);
      wait_done("single done");
      chk("single idle busy", 32'(busy), 32'd0);
      chk("single grant_id", 32'(grant_id), 32'd2);
      // ptr now 3: with requesters 0 and 3 valid, 3 must be offered first
      bus.req_valid = 4'b1001;
      #1;
      chk("single ptr=3", 32'(bus.req_ready), 32'h8);
      bus.req_valid = '0;
      tick();

      // Locked packet from requester 1, requester 0 waiting
      set_byte(1, 8'h11, 1'b0);
      set_byte(0, 8'h5A, 1'b1);
      bus.req_valid = 4'b0010;
      wait_ready("lock grant 0x11", 1);
      tick();
      bus.req_valid = 4'b0011;
      set_byte(1, 8'h22, 1'b0);
      chk("lock tx_data 0x11", 32'(bus.tx_data), 32'h11);
      wait_done("lock done 0x11");
      chk("lock busy held", 32'(busy), 32'd1);
      wait_ready("lock grant 0x22", 1);
      tick();
      set_byte(1, 8'h33, 1'b1);
      chk("lock tx_data 0x22", 32'(bus.tx_data), 32'h22);
      wait_done("lock done 0x22");
      wait_ready("lock grant 0x33", 1);
      tick();
      bus.req_valid = 4'b0001;
      chk("lock tx_data 0x33", 32'(bus.tx_data), 32'h33);
      wait_done("lock done 0x33");
      wait_ready("lock then req0", 0);
      tick();
      bus.req_valid = '0;
      chk("req0 tx_data", 32'(bus.tx_data), 32'h5A);
      chk("req0 grant_id", 32'(grant_id), 32'd0);
      wait_done("req0 done");

      // Stalled transmitter: ptr=1, requesters 1 and 2 valid
      tx_en = 1'b0;
      set_byte(1, 8'h66, 1'b1);
      set_byte(2, 8'h77, 1'b1);
      bus.req_valid = 4'b0110;
      wait_ready("stall grant req1", 1);
      tick();
      bus.req_valid = 4'b0100;
      chk("stall tx_start", 32'(bus.tx_start), 32'd1);
      chk("stall tx_data", 32'(bus.tx_data), 32'h66);
      cycles_to_err(n_cyc);
      // one ISSUE cycle plus 220 cycles in WAIT_DONE
      chk("stall err latency", 32'(n_cyc), 32'd221);
      chk("stall idle busy", 32'(busy), 32'd0);
      chk("stall next offered", 32'(bus.req_ready), 32'h4);
      tx_en = 1'b1;
      tick();
      bus.req_valid = '0;
      chk("stall err one pulse", 32'(err_timeout), 32'd0);
      chk("stall next tx_start", 32'(bus.tx_start), 32'd1);
      chk("stall next tx_data", 32'(bus.tx_data), 32'h77);
      chk("stall next grant_id", 32'(grant_id), 32'd2);
      wait_done("stall next done");

      // Abandoned lock by requester 3, requester 0 starved until timeout
      set_byte(3, 8'h44, 1'b0);
      bus.req_valid = 4'b1000;
      wait_ready("abandon grant req3", 3);
      tick();
      bus.req_valid = 4'b0001;
      chk("abandon tx_data", 32'(bus.tx_data), 32'h44);
      wait_done("abandon done");
      chk("abandon lock busy", 32'(busy), 32'd1);
      chk("abandon req0 starved", 32'(bus.req_ready), 32'd0);
      cycles_to_err(n_cyc);
      chk("abandon err latency", 32'(n_cyc), 32'd220);
      chk("abandon lock cleared", 32'(busy), 32'd0);
      chk("abandon req0 offered", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      chk("abandon req0 grant_id", 32'(grant_id), 32'd0);
      chk("abandon req0 tx_data", 32'(bus.tx_data), 32'h5A);
      wait_done("abandon req0 done");

      // Reset during WAIT_DONE
      set_byte(2, 8'h99, 1'b1);
      bus.req_valid = 4'b0100;
      wait_ready("midrst grant req2", 2);
      tick();
      bus.req_valid = '0;
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst tx_data", 32'(bus.tx_data), 32'd0);
      chk("midrst grant_id", 32'(grant_id), 32'd0);
      chk("midrst tx_start", 32'(bus.tx_start), 32'd0);
      chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst err_timeout", 32'(err_timeout), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fairness from ptr=0 with all four requesters always valid
      for (int i = 0; i < 4; i++) set_byte(i, 8'(8'hA0 + i), 1'b1);
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ready($sformatf("fair grant %0d", k), order[k]);
         tick();
         chk($sformatf("fair grant_id %0d", k), 32'(grant_id), 32'(order[k]));
         chk($sformatf("fair tx_data %0d", k), 32'(bus.tx_data), 32'(8'hA0 + order[k]));
         wait_done($sformatf("fair done %0d", k));
      end
      bus.req_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte producers.
- Uses round-robin arbitration. A requester can lock the grant across a multi-byte packet by holding req_last low.
- Sequences each byte: accept, issue a start pulse, wait for frame done.
- A watchdog recovers from a stalled transmitter or an abandoned lock.
- Sits between software/DMA byte sources and the uart_tx instance on the tx clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (>=2).
- DATA_WIDTH, 8: byte width, equal to the transmitter data width.
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line baud rate.
- TIMEOUT_CYCLES, localparam: 2*FRAME_BITS*CLK_FREQ/BAUD_RATE, where FRAME_BITS=11 (start + 8 data + parity + stop).

Ports:
- clk  in  1  system clock, same as the transmitter clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the last of its packet; low means keep the grant locked.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DATA_WIDTH  byte for the transmitter; stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- busy  out  1  arbiter not in IDLE, or lock held.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- err_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0, tx_start=0, tx_data=0, busy=0, grant_id=0, err_timeout=0.
  - Round-robin pointer ptr=0, lock=0, watchdog cnt=0.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Eligible set = req_valid when lock=0; only req_valid[grant_id] when lock=1.
  - Winner = first eligible index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in IDLE only.
  - Handshake completes at an edge with req_valid & req_ready. On that edge:
    - latch tx_data and grant_id;
    - set lock = ~req_last[winner];
    - clear cnt;
    - go to ISSUE.
- ISSUE: tx_start=1 for exactly this cycle; go to WAIT_DONE. Accept-to-start latency is 1 cycle.
- WAIT_DONE:
  - cnt increments each cycle.
  - On tx_done: if lock=0, set ptr = grant_id+1 (wrap). Go to IDLE in both cases.
  - tx_done is ignored in IDLE and ISSUE.
- Watchdog:
  - cnt also runs in IDLE while lock=1 and req_valid[grant_id]=0. It clears on any accept.
  - When cnt reaches TIMEOUT_CYCLES-1, on the next edge:
    - pulse err_timeout;
    - clear lock;
    - set ptr = grant_id+1;
    - go to IDLE.
  - A timeout in WAIT_DONE drops the byte. A tx_done on the same edge as the timeout wins: it is a normal completion and no error is raised.
- Back-to-back accepts: the earliest next accept is the cycle after tx_done is seen, i.e. 3 cycles of overhead per byte beyond the frame.
- Lock: other requesters are starved while lock=1, even if the locked requester has deasserted valid. Only req_last=1 or a timeout releases it.
- busy = (state!=IDLE) | lock.
- cnt width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Reset mid-frame: all state clears immediately. The partially sent frame is the transmitter's concern; no tx_start is issued until a new accept.

Decomposition:
- uart_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT_DONE);
  - FRAME_BITS=11;
  - a function computing TIMEOUT_CYCLES from CLK_FREQ and BAUD_RATE.
- Sub-module uart_rr_arbiter (combinational):
  - inputs: eligible mask and ptr;
  - outputs: one-hot grant, index and any_valid.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so TIMEOUT_CYCLES=220; transmitter model pulses tx_done 110 cycles after tx_start):
- Single byte: req_valid[2]=1, data 0xA5, last=1.
  - req_ready[2] high the same cycle; tx_start the next cycle with tx_data=0xA5.
  - After tx_done: busy=0, grant_id=2, ptr=3.
- Fairness: all four valid continuously with last=1 → grant order 0,1,2,3,0. No requester is granted twice before all others have been granted once.
- Locked packet: requester 1 sends 0x11 and 0x22 (last=0), then 0x33 (last=1) while requester 0 is valid throughout.
  - All three bytes from requester 1 go out before requester 0.
  - Requester 0 is granted after the 0x33 tx_done.
- Stalled transmitter: tx_done never arrives → err_timeout pulses once, 220 cycles after entering WAIT_DONE. The state returns to IDLE and the next requester is granted.
- Abandoned lock: requester 3 sends 0x44 with last=0, then drops valid.
  - err_timeout pulses 220 cycles after the tx_done; lock clears.
  - Requester 0 is then granted.
- Reset mid-operation: assert rst_n=0 during WAIT_DONE → all outputs go to 0 asynchronously. After release, the first grant goes to the lowest valid index (ptr=0).
